// File: rtl/ws2812b_rx_if.sv
// Word hand-off channel of the WS2812B receiver: the receiver drives the
// word and its valid flag, the consumer answers with ready.
interface ws2812b_rx_if;
    logic [23:0] data_out;
    logic        valid;
    logic        ready;

    modport master (output data_out, output valid, input ready);
    modport slave  (input data_out, input valid, output ready);
endinterface

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: measures high-pulse widths on an asynchronous
// line, decodes MSB-first 24-bit words and reports frame gaps and line errors.
module ws2812b_rx #(
    parameter int CLOCK_MHZ   = 64,
    parameter int THRESH_NS   = 600,
    parameter int MIN_HIGH_NS = 150,
    parameter int MAX_HIGH_NS = 2000,
    parameter int RESET_NS    = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din,
    ws2812b_rx_if.master    rx,
    output logic            frame_end,
    output logic            err_glitch,
    output logic            err_long,
    output logic            err_overrun,
    output logic            err_partial
);

    // Rounded nanosecond-to-cycle conversion, done at 64 bits and cut to 16.
    function automatic logic [15:0] ns_to_cyc(input longint mhz, input longint ns);
        longint c;
        c = (mhz * ns + 64'sd500) / 64'sd1000;
        return 16'(c);
    endfunction

    localparam logic [15:0] THRESH_C = ns_to_cyc(longint'(CLOCK_MHZ), longint'(THRESH_NS));
    localparam logic [15:0] MIN_C    = ns_to_cyc(longint'(CLOCK_MHZ), longint'(MIN_HIGH_NS));
    localparam logic [15:0] MAX_C    = ns_to_cyc(longint'(CLOCK_MHZ), longint'(MAX_HIGH_NS));
    localparam logic [15:0] RESET_C  = ns_to_cyc(longint'(CLOCK_MHZ), longint'(RESET_NS));

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } state_t;

    logic        sync1_r, sync2_r, prev_r;
    logic        rise_s, fall_s;
    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s, cnt_inc_s;
    logic [4:0]  bit_cnt_r, bit_cnt_s;
    logic [22:0] shift_r, shift_s;
    logic [23:0] word_r, word_s;
    logic        word_pend_r, word_pend_s;
    logic        word_seen_r, word_seen_s;
    logic        bit_s;
    logic        glitch_s, long_s, partial_s, fe_s;

    assign rise_s    = sync2_r & ~prev_r;
    assign fall_s    = prev_r & ~sync2_r;
    assign cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
    assign bit_s     = (cnt_r >= THRESH_C);

    // Two-flop synchronizer for din followed by the edge-detect flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Decoder next-state: width measurement, bit shifting and gap handling.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        word_s      = word_r;
        word_pend_s = 1'b0;
        word_seen_s = word_seen_r;
        glitch_s    = 1'b0;
        long_s      = 1'b0;
        partial_s   = 1'b0;
        fe_s        = 1'b0;
        case (state_r)
            ST_WAIT_GAP: begin
                if (sync2_r) begin
                    cnt_s = 16'd0;
                end else if (cnt_inc_s >= RESET_C) begin
                    cnt_s   = 16'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_IDLE: begin
                if (rise_s) begin
                    cnt_s   = 16'd1;
                    state_s = ST_HIGH;
                end else begin
                    cnt_s = 16'd0;
                end
            end
            ST_HIGH: begin
                // The long check wins over a coincident fall: width > MAX is an error.
                if (cnt_r > MAX_C) begin
                    long_s    = 1'b1;
                    bit_cnt_s = 5'd0;
                    cnt_s     = 16'd0;
                    state_s   = ST_WAIT_GAP;
                end else if (fall_s) begin
                    if (cnt_r < MIN_C) begin
                        glitch_s  = 1'b1;
                        bit_cnt_s = 5'd0;
                        cnt_s     = 16'd0;
                        state_s   = ST_WAIT_GAP;
                    end else begin
                        shift_s = {shift_r[21:0], bit_s};
                        cnt_s   = 16'd1;
                        state_s = ST_LOW;
                        if (bit_cnt_r == 5'd23) begin
                            bit_cnt_s   = 5'd0;
                            word_s      = {shift_r, bit_s};
                            word_pend_s = 1'b1;
                            word_seen_s = 1'b1;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 5'd1;
                        end
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    cnt_s   = 16'd1;
                    state_s = ST_HIGH;
                end else if (cnt_inc_s >= RESET_C) begin
                    if (bit_cnt_r != 5'd0) begin
                        partial_s = 1'b1;
                    end else begin
                        partial_s = 1'b0;
                    end
                    if (word_seen_r) begin
                        fe_s = 1'b1;
                    end else begin
                        fe_s = 1'b0;
                    end
                    bit_cnt_s   = 5'd0;
                    word_seen_s = 1'b0;
                    cnt_s       = 16'd0;
                    state_s     = ST_IDLE;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                cnt_s     = 16'd0;
                bit_cnt_s = 5'd0;
                state_s   = ST_WAIT_GAP;
            end
        endcase
    end

    // Decoder state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_WAIT_GAP;
            cnt_r       <= 16'd0;
            bit_cnt_r   <= 5'd0;
            shift_r     <= 23'd0;
            word_r      <= 24'd0;
            word_pend_r <= 1'b0;
            word_seen_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            word_r      <= word_s;
            word_pend_r <= word_pend_s;
            word_seen_r <= word_seen_s;
        end
    end

    // Output buffer and status pulses; a finished word loads if the buffer is
    // empty or being drained on this very edge, otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx.data_out <= 24'd0;
            rx.valid    <= 1'b0;
            frame_end   <= 1'b0;
            err_glitch  <= 1'b0;
            err_long    <= 1'b0;
            err_overrun <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            frame_end   <= fe_s;
            err_glitch  <= glitch_s;
            err_long    <= long_s;
            err_partial <= partial_s;
            err_overrun <= word_pend_r & rx.valid & ~rx.ready;
            if (word_pend_r && (!rx.valid || rx.ready)) begin
                rx.data_out <= word_r;
                rx.valid    <= 1'b1;
            end else if (rx.valid && rx.ready) begin
                rx.valid <= 1'b0;
            end else begin
                rx.valid <= rx.valid;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed/randomized bench for ws2812b_rx with a pulse-level reference model.
module tb_ws2812b_rx;

    localparam int MIN_W   = 10;
    localparam int THR_W   = 38;
    localparam int MAX_W   = 128;
    localparam int GAP_CYC = 3230;

    logic clk, rst_n, din;
    logic frame_end, err_glitch, err_long, err_overrun, err_partial;

    ws2812b_rx_if rx_if ();

    ws2812b_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .rx          (rx_if.master),
        .frame_end   (frame_end),
        .err_glitch  (err_glitch),
        .err_long    (err_long),
        .err_overrun (err_overrun),
        .err_partial (err_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // observed activity (written only by the monitor)
    logic [23:0] got_q[$];
    int n_fe = 0, n_glitch = 0, n_long = 0, n_over = 0, n_partial = 0;
    time hs_t = 0, fe_t = 0;

    // reference model state
    logic [23:0] exp_q[$];
    logic [23:0] m_acc;
    int  m_n, m_fe, m_glitch, m_long, m_over, m_partial;
    bit  m_ignore, m_since;
    int  chk_idx = 0;

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (rx_if.valid && rx_if.ready) begin
            got_q.push_back(rx_if.data_out);
            hs_t = $time;
        end
        if (frame_end) begin
            n_fe++;
            fe_t = $time;
        end
        if (err_glitch)  n_glitch++;
        if (err_long)    n_long++;
        if (err_overrun) n_over++;
        if (err_partial) n_partial++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic model_reset();
        m_ignore = 1'b1;
        m_n      = 0;
        m_since  = 1'b0;
        m_acc    = 24'd0;
    endtask

    // A high pulse of w clock samples, classified by the protocol rules.
    task automatic model_pulse(input int w);
        if (!m_ignore) begin
            if (w > MAX_W) begin
                m_long++;
                m_n = 0;
                m_ignore = 1'b1;
            end else if (w < MIN_W) begin
                m_glitch++;
                m_n = 0;
                m_ignore = 1'b1;
            end else begin
                m_acc = {m_acc[22:0], (w >= THR_W)};
                m_n++;
                if (m_n == 24) begin
                    exp_q.push_back(m_acc);
                    m_n = 0;
                    m_since = 1'b1;
                end
            end
        end
    endtask

    task automatic model_gap();
        if (m_ignore) begin
            m_ignore = 1'b0;
        end else begin
            if (m_n != 0) m_partial++;
            m_n = 0;
            if (m_since) m_fe++;
            m_since = 1'b0;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        cyc(hi);
        din = 1'b0;
        model_pulse(hi);
        if (lo > 0) cyc(lo);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nb, input bit fixed, input bit hold_last);
        for (int i = 0; i < nb; i++) begin
            logic b;
            int hi, lo;
            b = w[23 - i];
            if (fixed) begin
                hi = b ? 51 : 26;
                lo = 80 - hi;
            end else begin
                hi = b ? int'($urandom_range(60, THR_W)) : int'($urandom_range(THR_W - 1, MIN_W));
                lo = int'($urandom_range(30, 15));
            end
            pulse(hi, (hold_last && i == nb - 1) ? 0 : lo);
        end
    endtask

    task automatic gap();
        cyc(GAP_CYC);
        model_gap();
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int k = chk_idx; k < got_q.size() && k < exp_q.size(); k++)
            check({tag, "_word"}, got_q[k], exp_q[k]);
        chk_idx = exp_q.size();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_fe"},      n_fe,      m_fe);
        check({tag, "_glitch"},  n_glitch,  m_glitch);
        check({tag, "_long"},    n_long,    m_long);
        check({tag, "_overrun"}, n_over,    m_over);
        check({tag, "_partial"}, n_partial, m_partial);
    endtask

    initial begin
        logic [23:0] w1, w2, w3;
        m_fe = 0; m_glitch = 0; m_long = 0; m_over = 0; m_partial = 0;
        model_reset();
        din = 1'b0;
        rx_if.ready = 1'b1;
        rst_n = 1'b0;
        cyc(4);
        check("rst_valid", rx_if.valid, 1'b0);
        check("rst_data",  rx_if.data_out, 24'h0);
        check("rst_pulses", {frame_end, err_glitch, err_long, err_overrun, err_partial}, 5'b0);
        rst_n = 1'b1;
        gap();

        // 1: fixed-timing word with latency check on the final bit
        send_bits(24'hA5C3F0, 23, 1'b1, 1'b0);
        din = 1'b1;
        cyc(26);
        din = 1'b0;
        model_pulse(26);
        cyc(3);
        check("s1_valid_e2", rx_if.valid, 1'b0);
        cyc(1);
        check("s1_valid_e3", rx_if.valid, 1'b1);
        check("s1_data",     rx_if.data_out, 24'hA5C3F0);
        cyc(1);
        check("s1_consumed", rx_if.valid, 1'b0);
        cyc(50);
        gap();
        check_words("s1");
        check_counts("s1");

        // 2: two back-to-back words then one frame end
        send_bits(24'h123456, 24, 1'b0, 1'b0);
        send_bits(24'hFFFFFF, 24, 1'b0, 1'b0);
        gap();
        cyc(5);
        check_words("s2");
        check_counts("s2");
        check("s2_fe_after_hs", (fe_t > hs_t), 1'b1);

        // 3: stalled consumer, overrun, then ready exactly on load edge
        w1 = 24'($urandom);
        w2 = 24'($urandom);
        w3 = 24'($urandom);
        rx_if.ready = 1'b0;
        send_bits(w1, 24, 1'b0, 1'b0);
        check("s3_valid1", rx_if.valid, 1'b1);
        check("s3_hold1", rx_if.data_out, w1);
        send_bits(w2, 12, 1'b0, 1'b0);
        check("s3_hold_mid", rx_if.data_out, w1);
        send_bits(w2 << 12, 12, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        m_over++;
        check("s3_hold2", rx_if.data_out, w1);
        check("s3_overrun", n_over, m_over);
        send_bits(w3, 24, 1'b0, 1'b1);
        cyc(3);
        rx_if.ready = 1'b1;
        cyc(1);
        rx_if.ready = 1'b0;
        check("s3_valid3", rx_if.valid, 1'b1);
        check("s3_data3", rx_if.data_out, w3);
        cyc(20);
        rx_if.ready = 1'b1;
        cyc(3);
        gap();
        check_words("s3");
        check_counts("s3");

        // 4: width boundaries, glitch and long pulses
        pulse(37, 20);
        pulse(38, 20);
        pulse(128, 20);
        pulse(MIN_W, 20);
        send_bits(24'($urandom), 20, 1'b0, 1'b0);
        gap();
        check_words("s4_bound");
        check("s4_bound_bits", got_q.size() > 0 ? got_q[got_q.size()-1][23:20] : 4'hF, 4'b0110);
        send_bits(24'($urandom), 5, 1'b0, 1'b0);
        pulse(9, 20);
        send_bits(24'($urandom), 19, 1'b0, 1'b0);
        gap();
        check_words("s4_glitch");
        check_counts("s4_glitch");
        send_bits(24'($urandom), 3, 1'b0, 1'b0);
        pulse(129, 20);
        send_bits(24'($urandom), 21, 1'b0, 1'b0);
        gap();
        check_words("s4_long");
        check_counts("s4_long");

        // 5: partial word then a clean word
        send_bits(24'($urandom), 10, 1'b0, 1'b0);
        gap();
        check_words("s5_partial");
        check_counts("s5_partial");
        send_bits(24'($urandom), 24, 1'b0, 1'b0);
        gap();
        check_words("s5_word");
        check_counts("s5_word");

        // 6: reset mid-word with a buffered word
        rx_if.ready = 1'b0;
        send_bits(24'($urandom), 24, 1'b0, 1'b0);
        check("s6_buffered", rx_if.valid, 1'b1);
        send_bits(24'($urandom), 10, 1'b0, 1'b0);
        din = 1'b1;
        cyc(20);
        rst_n = 1'b0;
        cyc(1);
        check("s6_rst_valid", rx_if.valid, 1'b0);
        check("s6_rst_data", rx_if.data_out, 24'h0);
        rst_n = 1'b1;
        din = 1'b0;
        void'(exp_q.pop_back());
        model_reset();
        rx_if.ready = 1'b1;
        cyc(20);
        send_bits(24'($urandom), 24, 1'b0, 1'b0);
        check("s6_no_decode", rx_if.valid, 1'b0);
        gap();
        send_bits(24'($urandom), 24, 1'b0, 1'b0);
        gap();
        check_words("s6");
        check_counts("s6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
Single-wire WS2812B-protocol receiver/decoder. It sits at the other end of the LED-strip data line from our transmitter, used for loopback self-test and for daisy-chained peripherals. It measures high-pulse widths on an asynchronous input, decodes bits MSB-first into 24-bit colour words, and hands each word out over a valid/ready interface. It also flags frame end (reset gap) and protocol errors.

Parameters:
CLOCK_MHZ, 64, clk frequency in MHz; every cycle constant = round(CLOCK_MHZ*ns/1000), computed at 64-bit, truncated to 16 bits
THRESH_NS, 600, high width >= this decodes as '1', else '0' (64 MHz: 38 cycles)
MIN_HIGH_NS, 150, high width below this is a glitch (10 cycles)
MAX_HIGH_NS, 2000, high width above this is a stuck/long error (128 cycles)
RESET_NS, 50000, low time that ends a frame (3200 cycles)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
din  in  1  asynchronous serial line
data_out  out  24  received word, first-received bit in [23]
valid  out  1  data_out holds an unconsumed word
ready  in  1  consumer accepts word when valid&&ready
frame_end  out  1  one-cycle pulse: reset gap seen after >=1 complete word
err_glitch  out  1  one-cycle pulse: high pulse < MIN
err_long  out  1  one-cycle pulse: high pulse > MAX
err_overrun  out  1  one-cycle pulse: word completed while buffer full; word dropped
err_partial  out  1  one-cycle pulse: reset gap with 1..23 bits pending; bits dropped

Behaviour:
- Reset (rst_n=0 at posedge): data_out=0, valid=0, all pulses=0, bit count=0, counters=0, synchronizer flops=0, state=WAIT_GAP. Reset mid-word discards the word and any buffered word.
- din passes through a 2-flop synchronizer, then one edge-detect flop. Rise/fall are single-cycle strobes from the synchronized signal.
- One 16-bit saturating counter: counts high cycles in HIGH state, low cycles in LOW/WAIT_GAP.
- Measured high width = number of clk edges at which din was sampled high.
- States:
  - WAIT_GAP: ignore edges; line low for RESET cycles -> IDLE. A rise restarts the low count.
  - IDLE: rise -> HIGH, count=1.
  - HIGH: count++. Count > MAX -> err_long, clear bits, WAIT_GAP. On fall:
    - width < MIN -> err_glitch, clear bits, WAIT_GAP.
    - else shift in (width >= THRESH), bit count++, -> LOW with count=1.
  - LOW: rise -> HIGH, count=1. Count reaches RESET -> gap actions below, -> IDLE.
- Gap actions:
  - If bit count in 1..23 -> err_partial and clear bits.
  - If >=1 word completed since the last frame_end -> frame_end pulse.
  - If both apply, both pulse in the same cycle.
- 24th bit: the word loads data_out and sets valid if valid=0, or if valid&&ready in that same cycle (no overrun). Otherwise err_overrun, word dropped, data_out unchanged. Bit count returns to 0.
- valid stays high and data_out stays stable until valid&&ready; valid then clears on that edge unless a new word loads on the same edge.
- Latency: valid rises 3 clk edges after the first edge that samples the final falling din low.
- frame_end is independent of valid; it may pulse while a word is still unconsumed.
- Error pulses never assert outside the listed conditions; several may assert together only as stated above.

Test Plan:
- Reset, din low 3200 cycles, then 24 bits of pattern 0xA5C3F0 (high 26 cyc='0', 51 cyc='1', period 80 cyc), ready=1 -> valid one cycle with data_out=0xA5C3F0, no errors.
- Two words 0x123456, 0xFFFFFF back-to-back, then low 3200 cycles -> two valid handshakes in order, then exactly one frame_end pulse.
- ready=0 through two full words -> first word held stable in data_out, err_overrun on the second. ready=1 on the exact cycle the next word completes -> new word loaded, no overrun.
- Width boundaries: high 37 vs 38 cycles -> '0' vs '1'; 9 cycles -> err_glitch, word discarded; 129 cycles -> err_long; 128 cycles -> accepted as '1'.
- 10 bits, then low 3200 cycles -> err_partial, no frame_end, no valid. Next full word decodes correctly.
- Assert rst_n=0 mid-word with a word buffered -> valid=0 next cycle; nothing decodes until a 3200-cycle low gap is seen.
